svm_poly2_stream: RTL and testbench
===================================

# svm_poly2_stream

Parametrised, fully pipelined quadratic-kernel SVM classifier for the perceptron/SVM benchmark family. It accepts one NFEAT-feature fixed-point sample per cycle on a valid-qualified stream and scores it against a runtime-loadable weight file covering the constant, linear and all quadratic terms. It emits a signed margin and a binary label exactly three cycles later. A per-sample mode bit lets the same instance run as a linear classifier.

## Interface
- NFEAT, 2: number of input features (≥1)
- DATA_BW, 16: feature width, signed fixed point
- FRAC, 13: fractional bits of each feature
- WEIGHT_BW, 16: weight width, signed
- Derived, localparam: NTERMS = 1 + NFEAT + NFEAT*(NFEAT+1)/2; AW = max(1, clog2(NTERMS)); KBW = 2*DATA_BW; RBW = KBW + WEIGHT_BW; SUM_BW = RBW + clog2(NTERMS)
- clk  in  1  single clock, rising edge
- reset  in  1  asynchronous, active-high; clears all state
- in_valid  in  1  sample present this cycle
- in_data  in  NFEAT*DATA_BW  features; feature i occupies bits [i*DATA_BW +: DATA_BW]
- in_mode  in  1  0 = quadratic kernel, 1 = linear only (quadratic terms forced to 0); travels with the sample
- wr_en  in  1  weight write strobe
- wr_addr  in  AW  term index to write
- wr_data  in  WEIGHT_BW  signed weight
- out_valid  out  1  margin/label valid
- out_margin  out  SUM_BW  signed decision sum
- out_label  out  1  1 when out_margin ≥ 0, else 0

## Operation
- Term order: index 0 = constant 1.0; indices 1..NFEAT = x_0..x_{NFEAT-1}; remaining indices = products x_i*x_j for i ≤ j, with i outer and j inner ascending. For NFEAT=2: 0 const, 1 x0, 2 x1, 3 x0x0, 4 x0x1, 5 x1x1.
- Kernel terms are KBW-bit signed values with 2*FRAC fractional bits:
  - constant = 1 << (2*FRAC)
  - linear = sign-extended x_i << FRAC
  - quadratic = full-precision x_i*x_j, or 0 when the sample's mode = 1
- Weighted term: weight[k] * term[k], RBW bits, full precision, signed.
- Margin: sum of all NTERMS weighted terms in SUM_BW bits. This width cannot overflow, so no saturation or truncation is applied.
- Weight file: NTERMS registers, all reset to 0.
  - On a wr_en edge, weight[wr_addr] ← wr_data.
  - wr_addr ≥ NTERMS: write ignored, no other register changes.
  - Writes are legal at any time, including while samples are in flight.
- There is no backpressure; every in_valid sample produces exactly one out_valid result.

## Timing
- Stage 1 (edge k, in_valid=1): register the kernel terms, mode masking applied, and v1 ← 1.
- Stage 2 (edge k+1): register the weighted terms, using the weight file contents at that edge, and v2 ← v1.
- Stage 3 (edge k+2): register out_margin = adder-tree sum, out_label = ~sum[SUM_BW-1], and out_valid ← v2.
- Latency: out_valid is high in the cycle after edge k+2, i.e. 3 cycles after in_valid. Throughput is 1 sample per cycle, and back-to-back samples give contiguous out_valid.
- Weight visibility: a write captured at or before a sample's stage-1 edge k applies to that sample. A write at edge k+1 or later does not.
- When out_valid=0, out_margin and out_label hold their last values; the sum register is not updated from invalid data.
- Reset values: out_valid=0, out_margin=0, out_label=0, v1=v2=0, all weights=0, all kernel and product registers=0.
- Reset mid-operation: all in-flight samples are discarded and no out_valid is produced for them. The first sample after deassertion has normal 3-cycle latency and sees zero weights unless rewritten.

## Test plan
- Reset then idle → out_valid, out_margin and out_label all 0. Write w0=8192 and stream x=(0,0) → after 3 cycles margin=2^39=549755813888, label=1.
- Linear sign: weights 0 except w1=8192; x0=-8192, x1=5000 → margin=-549755813888, label=0. Then x0=+8192 → margin=+549755813888, label=1.
- Quadratic and mode: weights 0 except w3=8192; x0=16384 (2.0) with mode=0 → margin=2^41=2199023255552, label=1. Same sample with mode=1 → margin=0, label=1.
- Streaming and weight timing: 4 back-to-back samples → out_valid high 4 contiguous cycles, in order. Write w1 at a sample's stage-2 edge → that sample uses the old w1 and the next sample uses the new w1. wr_addr=6,7 with NFEAT=2 → no weight changes.
- Reset mid-flight: in_valid pulse, reset asserted the next cycle for 1 cycle → out_valid never rises and all weights read back as 0 via the constant-only margin of a follow-up sample (margin=0, label=1).
- Parameter sweep: NFEAT=3 (NTERMS=10, SUM_BW=52); set one weight per term to 8192 with all features 1.0 (8192) → margin=10*2^39.

Source files
------------

// File: rtl/svm_poly2_stream.sv
`default_nettype none
// ============================================================================
// svm_poly2_stream -- streaming quadratic-kernel SVM scorer, 3-stage pipeline
// Revision: 1.0
// ============================================================================
module svm_poly2_stream #(
  parameter int NFEAT     = 2,
  parameter int DATA_BW   = 16,
  parameter int FRAC      = 13,
  parameter int WEIGHT_BW = 16,
  localparam int NTERMS   = 1 + NFEAT + NFEAT*(NFEAT+1)/2,
  localparam int AW       = (NTERMS > 2) ? $clog2(NTERMS) : 1,
  localparam int KBW      = 2*DATA_BW,
  localparam int RBW      = KBW + WEIGHT_BW,
  localparam int SUM_BW   = RBW + $clog2(NTERMS)
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     in_valid,
  input  logic [NFEAT*DATA_BW-1:0] in_data,
  input  logic                     in_mode,
  input  logic                     wr_en,
  input  logic [AW-1:0]            wr_addr,
  input  logic [WEIGHT_BW-1:0]     wr_data,
  output logic                     out_valid,
  output logic [SUM_BW-1:0]        out_margin,
  output logic                     out_label
);

  logic signed [KBW-1:0]       feat_x   [NFEAT];
  logic signed [KBW-1:0]       term_q   [NTERMS];
  logic signed [KBW-1:0]       term_d   [NTERMS];
  logic signed [RBW-1:0]       prod_q   [NTERMS];
  logic signed [RBW-1:0]       prod_d   [NTERMS];
  logic signed [WEIGHT_BW-1:0] weight_q [NTERMS];
  logic signed [WEIGHT_BW-1:0] weight_d [NTERMS];
  logic signed [SUM_BW-1:0]    margin_q, margin_d, acc;
  logic                        label_q, label_d;
  logic                        v1_q, v1_d, v2_q, v2_d, valid_q, valid_d;

  for (genvar i = 0; i < NFEAT; i++) begin : g_feat
    assign feat_x[i] = {{(KBW-DATA_BW){in_data[i*DATA_BW+DATA_BW-1]}},
                        in_data[i*DATA_BW +: DATA_BW]};
  end

  // Stage 1: kernel terms in Q(2*FRAC); quadratic products packed i-outer, j-inner.
  always_comb begin
    int k;
    k = NFEAT + 1;
    for (int t = 0; t < NTERMS; t++) term_d[t] = term_q[t];
    if (in_valid) begin
      term_d[0] = {{(KBW-1){1'b0}}, 1'b1} << (2*FRAC);
      for (int i = 0; i < NFEAT; i++) term_d[1+i] = feat_x[i] <<< FRAC;
      for (int i = 0; i < NFEAT; i++) begin
        for (int j = i; j < NFEAT; j++) begin
          if (in_mode) term_d[k] = '0;
          else         term_d[k] = feat_x[i] * feat_x[j];
          k = k + 1;
        end
      end
    end
  end

  // Stage 2: operands widened to RBW so the truncated product is exact.
  always_comb begin
    for (int t = 0; t < NTERMS; t++) begin
      prod_d[t] = prod_q[t];
      if (v1_q)
        prod_d[t] = {{(RBW-WEIGHT_BW){weight_q[t][WEIGHT_BW-1]}}, weight_q[t]} *
                    {{(RBW-KBW){term_q[t][KBW-1]}}, term_q[t]};
    end
  end

  // Stage 3: the sum register only loads from valid products.
  always_comb begin
    acc = '0;
    for (int t = 0; t < NTERMS; t++)
      acc = acc + {{(SUM_BW-RBW){prod_q[t][RBW-1]}}, prod_q[t]};
    margin_d = margin_q;
    label_d  = label_q;
    if (v2_q) begin
      margin_d = acc;
      label_d  = ~acc[SUM_BW-1];
    end
  end

  always_comb begin
    for (int t = 0; t < NTERMS; t++) weight_d[t] = weight_q[t];
    if (wr_en && (int'(wr_addr) < NTERMS)) weight_d[wr_addr] = wr_data;
  end

  assign v1_d    = in_valid;
  assign v2_d    = v1_q;
  assign valid_d = v2_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int t = 0; t < NTERMS; t++) begin
        term_q[t]   <= '0;
        prod_q[t]   <= '0;
        weight_q[t] <= '0;
      end
      margin_q <= '0;
      label_q  <= 1'b0;
      v1_q     <= 1'b0;
      v2_q     <= 1'b0;
      valid_q  <= 1'b0;
    end else begin
      for (int t = 0; t < NTERMS; t++) begin
        term_q[t]   <= term_d[t];
        prod_q[t]   <= prod_d[t];
        weight_q[t] <= weight_d[t];
      end
      margin_q <= margin_d;
      label_q  <= label_d;
      v1_q     <= v1_d;
      v2_q     <= v2_d;
      valid_q  <= valid_d;
    end
  end

  assign out_valid  = valid_q;
  assign out_margin = margin_q;
  assign out_label  = label_q;

endmodule
`default_nettype wire

// File: tb/tb_svm_poly2_stream.sv
`default_nettype none
// ============================================================================
// tb_svm_poly2_stream -- directed + randomized checks against a term-sum model
// Revision: 1.0
// ============================================================================
module tb_svm_poly2_stream;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        in_valid = 1'b0, in_mode = 1'b0, wr_en = 1'b0;
  logic [31:0] in_data = '0;
  logic [2:0]  wr_addr = '0;
  logic [15:0] wr_data = '0;
  logic        out_valid, out_label;
  logic [50:0] out_margin;

  logic        d3_in_valid = 1'b0, d3_wr_en = 1'b0;
  logic [47:0] d3_in_data = '0;
  logic [3:0]  d3_wr_addr = '0;
  logic [15:0] d3_wr_data = '0;
  logic        d3_out_valid, d3_out_label;
  logic [51:0] d3_out_margin;

  svm_poly2_stream u_dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_data(in_data),
    .in_mode(in_mode), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .out_valid(out_valid), .out_margin(out_margin), .out_label(out_label));

  svm_poly2_stream #(.NFEAT(3)) u_dut3 (
    .clk(clk), .reset(reset), .in_valid(d3_in_valid), .in_data(d3_in_data),
    .in_mode(1'b0), .wr_en(d3_wr_en), .wr_addr(d3_wr_addr), .wr_data(d3_wr_data),
    .out_valid(d3_out_valid), .out_margin(d3_out_margin), .out_label(d3_out_label));

  always #5 clk = ~clk;

  typedef struct { longint m; int due; } exp_t;
  exp_t   q[$];
  longint mw[6];
  longint last_m = 0;
  bit     last_l = 1'b0;
  int     cyc = 0;
  int     checks = 0;
  int     failures = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  // Reference: explicit term list, each term times its weight, plain 64-bit sum.
  function automatic longint model(input int x0, input int x1, input bit m);
    longint x[2];
    longint t[6];
    longint s;
    int     k;
    x[0] = x0; x[1] = x1;
    t[0] = longint'(1) << 26;
    for (int i = 0; i < 2; i++) t[1+i] = x[i] * 8192;
    k = 3;
    for (int i = 0; i < 2; i++)
      for (int j = i; j < 2; j++) begin
        t[k] = m ? 0 : x[i] * x[j];
        k++;
      end
    s = 0;
    for (int i = 0; i < 6; i++) s += mw[i] * t[i];
    return s;
  endfunction

  task automatic drive(input bit v, input int x0, input int x1, input bit m,
                       input bit we, input int wa, input int wd);
    exp_t e;
    in_valid = v; in_mode = m; wr_en = we;
    in_data  = {x1[15:0], x0[15:0]};
    wr_addr  = wa[2:0];
    wr_data  = wd[15:0];
    if (we && wa < 6) mw[wa] = wd;
    if (v) begin
      e.m = model(x0, x1, m);
      e.due = cyc + 3;
      q.push_back(e);
    end
    @(posedge clk); #1;
    in_valid = 1'b0; wr_en = 1'b0; in_mode = 1'b0;
  endtask

  task automatic wr(input int wa, input int wd);
    drive(1'b0, 0, 0, 1'b0, 1'b1, wa, wd);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    q.delete();
    for (int i = 0; i < 6; i++) mw[i] = 0;
    last_m = 0;
    last_l = 1'b0;
    @(posedge clk); #1;
    reset = 1'b0;
  endtask

  task automatic send_check(input string name, input int x0, input int x1,
                            input bit m, input longint em, input bit el);
    drive(1'b1, x0, x1, m, 1'b0, 0, 0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk({name, "_valid"}, longint'(out_valid), 1);
    chk({name, "_margin"}, $signed(out_margin), em);
    chk({name, "_label"}, longint'(out_label), longint'(el));
  endtask

  // Cycle-by-cycle compare: valid timing, margin/label on valid, hold otherwise.
  always @(negedge clk) begin
    bit     ev, el;
    longint em;
    exp_t   e;
    ev = 1'b0; em = last_m; el = last_l;
    if (q.size() > 0 && q[0].due == cyc) begin
      e  = q.pop_front();
      ev = 1'b1;
      em = e.m;
      el = (em >= 0);
    end
    chk("stream_valid", longint'(out_valid), longint'(ev));
    chk("stream_margin", $signed(out_margin), em);
    chk("stream_label", longint'(out_label), longint'(el));
    if (ev) begin
      last_m = em;
      last_l = el;
    end
  end

  initial begin
    int     nv, first_c, last_c;
    longint got[4];
    for (int i = 0; i < 6; i++) mw[i] = 0;
    repeat (2) @(posedge clk); #1;
    do_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset_valid", longint'(out_valid), 0);
    chk("reset_margin", $signed(out_margin), 0);
    chk("reset_label", longint'(out_label), 0);
    @(posedge clk); #1;

    wr(0, 8192);
    send_check("const", 0, 0, 1'b0, 64'sd549755813888, 1'b1);

    wr(0, 0);
    wr(1, 8192);
    send_check("lin_neg", -8192, 5000, 1'b0, -64'sd549755813888, 1'b0);
    send_check("lin_pos", 8192, 5000, 1'b0, 64'sd549755813888, 1'b1);

    wr(1, 0);
    wr(3, 8192);
    send_check("quad_m0", 16384, 0, 1'b0, 64'sd2199023255552, 1'b1);
    send_check("quad_m1", 16384, 0, 1'b1, 0, 1'b1);

    // Back-to-back stream; w1 changes at sample A's stage-2 edge.
    wr(3, 0);
    wr(1, 1);
    nv = 0; first_c = -1; last_c = -1;
    fork
      begin
        drive(1'b1, 8192, 0, 1'b0, 1'b0, 0, 0);
        drive(1'b1, 8192, 0, 1'b0, 1'b1, 1, 2);
        drive(1'b1, 16384, 0, 1'b0, 1'b0, 0, 0);
        drive(1'b1, -8192, 0, 1'b0, 1'b0, 0, 0);
      end
      begin
        for (int i = 0; i < 10; i++) begin
          @(negedge clk);
          if (out_valid) begin
            if (nv < 4) got[nv] = $signed(out_margin);
            if (first_c < 0) first_c = i;
            last_c = i;
            nv++;
          end
        end
      end
    join
    chk("burst_count", nv, 4);
    chk("burst_contig", last_c - first_c, 3);
    chk("burst_a_old_w1", got[0], 64'sd67108864);
    chk("burst_b_new_w1", got[1], 64'sd134217728);
    chk("burst_c", got[2], 64'sd268435456);
    chk("burst_d", got[3], -64'sd134217728);

    wr(6, 999);
    wr(7, -5);
    send_check("oob_write", 8192, 0, 1'b0, 64'sd134217728, 1'b1);

    // Mid-flight reset discards the sample and clears every weight.
    wr(0, 100);
    for (int i = 1; i < 6; i++) wr(i, 7);
    nv = 0;
    fork
      begin
        drive(1'b1, 8192, 8192, 1'b0, 1'b0, 0, 0);
        do_reset();
      end
      begin
        for (int i = 0; i < 8; i++) begin
          @(negedge clk);
          if (out_valid) nv++;
        end
      end
    join
    chk("rst_flight_no_valid", nv, 0);
    send_check("rst_w0_zero", 0, 0, 1'b0, 0, 1'b1);
    send_check("rst_all_zero", 8192, -8192, 1'b0, 0, 1'b1);

    for (int n = 0; n < 400; n++) begin
      drive($urandom_range(0, 9) < 7,
            int'($urandom_range(0, 65535)) - 32768,
            int'($urandom_range(0, 65535)) - 32768,
            $urandom_range(0, 1) == 1,
            $urandom_range(0, 4) == 0,
            int'($urandom_range(0, 7)),
            int'($urandom_range(0, 65535)) - 32768);
    end
    repeat (5) @(posedge clk);

    // NFEAT=3 instance: every term weighted by 1.0.
    for (int k = 0; k < 10; k++) begin
      d3_wr_en = 1'b1; d3_wr_addr = k[3:0]; d3_wr_data = 16'd8192;
      @(posedge clk); #1;
    end
    d3_wr_en = 1'b0;
    d3_in_valid = 1'b1; d3_in_data = {3{16'd8192}};
    @(posedge clk); #1;
    d3_in_valid = 1'b1; d3_in_data = {3{16'he000}};
    @(posedge clk); #1;
    d3_in_valid = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk("n3_pos_valid", longint'(d3_out_valid), 1);
    chk("n3_pos_margin", $signed(d3_out_margin), 64'sd5497558138880);
    chk("n3_pos_label", longint'(d3_out_label), 1);
    @(negedge clk);
    chk("n3_neg_margin", $signed(d3_out_margin), 64'sd2199023255552);
    @(negedge clk);
    chk("n3_idle_valid", longint'(d3_out_valid), 0);
    chk("n3_hold_margin", $signed(d3_out_margin), 64'sd2199023255552);

    chk("queue_drained", q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
